id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have port: clk_i  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: stall_i  in  1  hold stage contents.
REQ-005 SHALL have port: flush_i  in  1  replace stage contents with bubble.
REQ-006 SHALL have port: valid_i  in  1  decode-stage instruction valid.
REQ-007 SHALL have ports: rs1_data_i, rs2_data_i, imm_i  in  DATA_W  register-file reads and sign-extended immediate.
REQ-008 SHALL have ports: rs1_addr_i, rs2_addr_i, rd_addr_i  in  5  source/destination register indices.
REQ-009 SHALL have ports: alu_ctrl_i  in  3  ALU opcode; alu_src_i  in  1  (1 = immediate as operand 2); reg_write_i  in  1  write-back enable.
REQ-010 SHALL have ports: exmem_rd_i  in  5, exmem_reg_write_i  in  1, exmem_data_i  in  DATA_W  EX/MEM forwarding source.
REQ-011 SHALL have ports: memwb_rd_i  in  5, memwb_reg_write_i  in  1, memwb_data_i  in  DATA_W  MEM/WB forwarding source.
REQ-012 SHALL have ports: valid_o  out  1; data1_o, data2_o  out  DATA_W  ALU operands; alu_ctrl_o  out  3; rd_addr_o  out  5; reg_write_o  out  1.

Function
REQ-013 SHALL register valid, rs1/rs2 data, imm, rs1/rs2/rd addresses, alu_ctrl, alu_src, reg_write on each clk_i rising edge when neither rst_i, flush_i nor stall_i is asserted; latency one cycle.
REQ-014 SHALL, on flush_i, load a bubble: valid_o=0, reg_write_o=0, alu_ctrl_o=000, rd_addr_o=0, data registers 0.
REQ-015 SHALL give priority rst_i > flush_i > stall_i; flush with stall simultaneously yields a bubble.
REQ-016 SHALL, on stall_i, hold all registers, except that a held rs1/rs2 data register SHALL be overwritten with memwb_data_i when memwb_reg_write_i=1, memwb_rd_i!=0 and memwb_rd_i equals the held address (prevents stale operand after the writer retires).
REQ-017 SHALL form forwarded operand A combinationally: exmem_data_i if exmem_reg_write_i=1, exmem_rd_i!=0, exmem_rd_i==held rs1 addr; else memwb_data_i under the same test on MEM/WB; else held rs1 data.
REQ-018 SHALL form forwarded operand B identically from held rs2 addr/data; EX/MEM SHALL win when both sources match.
REQ-019 SHALL drive data1_o = operand A; data2_o = held imm when held alu_src=1, else operand B.
REQ-020 SHALL never forward to register index 0; reads of x0 pass held data unchanged.
REQ-021 SHALL forward regardless of valid_o; downstream qualifies with valid_o.
REQ-022 SHALL drive alu_ctrl_o, rd_addr_o, reg_write_o directly from held registers; reg_write_o SHALL be 0 whenever valid_o=0.
REQ-023 SHALL treat valid_i=0 captures as bubbles (reg_write forced 0).

Reset
REQ-024 SHALL, while rst_i=1 at a rising edge, clear all registers: valid_o=0, reg_write_o=0, alu_ctrl_o=000, rd_addr_o=0, stored data/imm/addresses 0.
REQ-025 SHALL let reset mid-stall or mid-flush override both within the same edge; outputs (data1_o/data2_o excepted, which follow forwarding) are reset values the following cycle.

Structure
REQ-026 SHALL take the 3-bit ALU opcode encodings (AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111) and the x0 index constant from the shared CPU package.
REQ-027 SHALL place operand selection in one sub-module, forward_unit, taking held rs addresses and both forwarding sources and returning 2-bit select per operand (00 held, 01 MEM/WB, 10 EX/MEM).

Verification
REQ-028 SHALL cover: rs1=5 data 0x10, rs2=6 data 0x20, alu_src=0, alu_ctrl=011, no forwarding -> next cycle data1_o=0x10, data2_o=0x20, alu_ctrl_o=011, valid_o=1.
REQ-029 SHALL cover: held rs1=5, exmem_rd=5 data 0xAA, memwb_rd=5 data 0xBB, both write -> data1_o=0xAA; drop exmem_reg_write -> data1_o=0xBB.
REQ-030 SHALL cover: held rs2=0, exmem_rd=0 write data 0xFF, alu_src=0 -> data2_o=held rs2 data (0), not 0xFF; alu_src=1, imm=0xFFFFFFFC -> data2_o=0xFFFFFFFC.
REQ-031 SHALL cover: stall 3 cycles with held rs1=7 data 0x1, memwb_rd=7 data 0x99 writing in cycle 2 -> after stall release with no forwarding, data1_o=0x99; other outputs unchanged throughout stall.
REQ-032 SHALL cover: flush_i and stall_i together with reg_write_i=1 -> next cycle valid_o=0, reg_write_o=0, rd_addr_o=0.
REQ-033 SHALL cover: rst_i asserted during stall with valid stage -> next cycle valid_o=0, reg_write_o=0, alu_ctrl_o=000; first capture after rst_i deasserted appears one cycle later.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared CPU definitions used by the ID/EX pipeline stage:
//   - alu_op_e  : 3-bit ALU opcode encodings
//   - REG_X0    : index of the hard-wired zero register
//   - fwd_sel_e : operand source select produced by the forwarding unit
//   - fwd_hit() : "this write-back source produces the register we read" test
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_op_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_HELD  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // x0 is never a forwarding target: its value is architecturally constant.
  function automatic logic fwd_hit(input logic       we,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Chooses the source of each ALU operand from the held source register indices
// and the two in-flight write-back sources. EX/MEM is younger than MEM/WB, so
// it wins when both match.
// Ports:
//   rs1_addr_i, rs2_addr_i  held source register indices
//   exmem_rd_i, exmem_reg_write_i  EX/MEM destination and write enable
//   memwb_rd_i, memwb_reg_write_i  MEM/WB destination and write enable
//   fwd_a_o, fwd_b_o        operand select (00 held, 01 MEM/WB, 10 EX/MEM)
// -----------------------------------------------------------------------------
module forward_unit
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       exmem_reg_write_i,
  input  logic [4:0] memwb_rd_i,
  input  logic       memwb_reg_write_i,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);

  function automatic fwd_sel_e pick(input logic [4:0] rs);
    if (fwd_hit(exmem_reg_write_i, exmem_rd_i, rs))      return FWD_EXMEM;
    else if (fwd_hit(memwb_reg_write_i, memwb_rd_i, rs)) return FWD_MEMWB;
    else                                                 return FWD_HELD;
  endfunction

  always_comb begin
    fwd_a_o = pick(rs1_addr_i);
    fwd_b_o = pick(rs2_addr_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding on its output side.
// Ports:
//   clk_i, rst_i (sync, active-high), stall_i (hold), flush_i (bubble)
//   valid_i, rs1/rs2_data_i, imm_i, rs1/rs2/rd_addr_i, alu_ctrl_i, alu_src_i,
//   reg_write_i                      decode-stage instruction fields
//   exmem_rd_i/_reg_write_i/_data_i  EX/MEM forwarding source
//   memwb_rd_i/_reg_write_i/_data_i  MEM/WB forwarding source
//   valid_o, data1_o, data2_o, alu_ctrl_o, rd_addr_o, reg_write_o
// Priority on the clock edge: reset > flush > stall > capture.
// -----------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [2:0]        alu_ctrl_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic [4:0]        exmem_rd_i,
  input  logic              exmem_reg_write_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic [4:0]        memwb_rd_i,
  input  logic              memwb_reg_write_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_write_o
);

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [4:0]        rs1_addr_q,  rs1_addr_d;
  logic [4:0]        rs2_addr_q,  rs2_addr_d;
  logic [4:0]        rd_addr_q,   rd_addr_d;
  alu_op_e           alu_ctrl_q,  alu_ctrl_d;
  logic              alu_src_q,   alu_src_d;
  logic              reg_write_q, reg_write_d;

  fwd_sel_e          fwd_a, fwd_b;
  logic [DATA_W-1:0] op_a, op_b;

  always_comb begin
    // Hold by default; this is the stall behaviour.
    valid_d     = valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;

    if (flush_i) begin
      valid_d     = 1'b0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_addr_d  = REG_X0;
      rs2_addr_d  = REG_X0;
      rd_addr_d   = REG_X0;
      alu_ctrl_d  = ALU_AND;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall_i) begin
      // A writer retiring from MEM/WB while we are held would otherwise leave
      // a stale operand once it is no longer available for forwarding.
      if (fwd_hit(memwb_reg_write_i, memwb_rd_i, rs1_addr_q)) rs1_data_d = memwb_data_i;
      if (fwd_hit(memwb_reg_write_i, memwb_rd_i, rs2_addr_q)) rs2_data_d = memwb_data_i;
    end else begin
      valid_d     = valid_i;
      rs1_data_d  = rs1_data_i;
      rs2_data_d  = rs2_data_i;
      imm_d       = imm_i;
      rs1_addr_d  = rs1_addr_i;
      rs2_addr_d  = rs2_addr_i;
      rd_addr_d   = rd_addr_i;
      alu_ctrl_d  = alu_op_e'(alu_ctrl_i);
      alu_src_d   = alu_src_i;
      reg_write_d = reg_write_i & valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= REG_X0;
      rs2_addr_q  <= REG_X0;
      rd_addr_q   <= REG_X0;
      alu_ctrl_q  <= ALU_AND;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
    end
  end

  forward_unit u_forward_unit (
    .rs1_addr_i        (rs1_addr_q),
    .rs2_addr_i        (rs2_addr_q),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b)
  );

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: op_a = exmem_data_i;
      FWD_MEMWB: op_a = memwb_data_i;
      default:   op_a = rs1_data_q;
    endcase
    case (fwd_b)
      FWD_EXMEM: op_b = exmem_data_i;
      FWD_MEMWB: op_b = memwb_data_i;
      default:   op_b = rs2_data_q;
    endcase
  end

  assign valid_o     = valid_q;
  assign data1_o     = op_a;
  assign data2_o     = alu_src_q ? imm_q : op_b;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign rd_addr_o   = rd_addr_q;
  // Redundant with the capture-time masking, but keeps the output safe by
  // construction whatever state the registers hold.
  assign reg_write_o = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, stall, flush, valid_in;
  logic [DATA_W-1:0] rs1_data, rs2_data, imm;
  logic [4:0]        rs1_addr, rs2_addr, rd_addr;
  logic [2:0]        alu_ctrl;
  logic              alu_src, reg_write;
  logic [4:0]        exmem_rd, memwb_rd;
  logic              exmem_we, memwb_we;
  logic [DATA_W-1:0] exmem_data, memwb_data;

  logic              valid_out, reg_write_out;
  logic [DATA_W-1:0] data1, data2;
  logic [2:0]        alu_ctrl_out;
  logic [4:0]        rd_addr_out;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .valid_i           (valid_in),
    .rs1_data_i        (rs1_data),
    .rs2_data_i        (rs2_data),
    .imm_i             (imm),
    .rs1_addr_i        (rs1_addr),
    .rs2_addr_i        (rs2_addr),
    .rd_addr_i         (rd_addr),
    .alu_ctrl_i        (alu_ctrl),
    .alu_src_i         (alu_src),
    .reg_write_i       (reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_reg_write_i (exmem_we),
    .exmem_data_i      (exmem_data),
    .memwb_rd_i        (memwb_rd),
    .memwb_reg_write_i (memwb_we),
    .memwb_data_i      (memwb_data),
    .valid_o           (valid_out),
    .data1_o           (data1),
    .data2_o           (data2),
    .alu_ctrl_o        (alu_ctrl_out),
    .rd_addr_o         (rd_addr_out),
    .reg_write_o       (reg_write_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    exmem_rd = 5'd0; exmem_we = 1'b0; exmem_data = '0;
    memwb_rd = 5'd0; memwb_we = 1'b0; memwb_data = '0;
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] im,
                       input logic [4:0] rd, input logic [2:0] op, input logic src,
                       input logic we);
    valid_in = v; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
    imm = im; rd_addr = rd; alu_ctrl = op; alu_src = src; reg_write = we;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0);
    no_fwd();

    // Reset state
    step();
    check("rst_valid",  {31'b0, valid_out}, 32'h0);
    check("rst_rw",     {31'b0, reg_write_out}, 32'h0);
    check("rst_alu",    {29'b0, alu_ctrl_out}, 32'h0);
    check("rst_rd",     {27'b0, rd_addr_out}, 32'h0);
    check("rst_data1",  data1, 32'h0);
    check("rst_data2",  data2, 32'h0);

    // Basic capture, ADD, no forwarding
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h10, 5'd6, 32'h20, 32'h1234, 5'd9, 3'b011, 1'b0, 1'b1);
    step();
    check("cap_data1",  data1, 32'h10);
    check("cap_data2",  data2, 32'h20);
    check("cap_alu",    {29'b0, alu_ctrl_out}, 32'h3);
    check("cap_valid",  {31'b0, valid_out}, 32'h1);
    check("cap_rd",     {27'b0, rd_addr_out}, 32'h9);
    check("cap_rw",     {31'b0, reg_write_out}, 32'h1);

    // Forwarding priority on operand A, then B
    exmem_rd = 5'd5; exmem_we = 1'b1; exmem_data = 32'hAA;
    memwb_rd = 5'd5; memwb_we = 1'b1; memwb_data = 32'hBB;
    #1 check("fwdA_exmem", data1, 32'hAA);
    check("fwdA_data2_untouched", data2, 32'h20);
    exmem_we = 1'b0;
    #1 check("fwdA_memwb", data1, 32'hBB);
    exmem_rd = 5'd6; exmem_we = 1'b1; memwb_rd = 5'd6;
    #1 check("fwdB_exmem", data2, 32'hAA);
    check("fwdB_data1_held", data1, 32'h10);
    exmem_we = 1'b0;
    #1 check("fwdB_memwb", data2, 32'hBB);
    no_fwd();

    // x0 is never forwarded; immediate select
    drive(1'b1, 5'd1, 32'h5, 5'd0, 32'h0, 32'hFFFFFFFC, 5'd2, 3'b110, 1'b0, 1'b1);
    step();
    exmem_rd = 5'd0; exmem_we = 1'b1; exmem_data = 32'hFF;
    memwb_rd = 5'd0; memwb_we = 1'b1; memwb_data = 32'hEE;
    #1 check("x0_no_fwd", data2, 32'h0);
    check("x0_data1", data1, 32'h5);
    drive(1'b1, 5'd1, 32'h5, 5'd0, 32'h0, 32'hFFFFFFFC, 5'd2, 3'b110, 1'b1, 1'b1);
    step();
    check("imm_sel", data2, 32'hFFFFFFFC);
    no_fwd();

    // valid_i=0 capture is a bubble
    drive(1'b0, 5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 5'd5, 3'b001, 1'b0, 1'b1);
    step();
    check("bub_valid", {31'b0, valid_out}, 32'h0);
    check("bub_rw",    {31'b0, reg_write_out}, 32'h0);

    // Stall for three edges with a MEM/WB writer retiring in the second
    drive(1'b1, 5'd7, 32'h1, 5'd8, 32'h2, 32'h0, 5'd3, 3'b101, 1'b0, 1'b1);
    step();
    check("stl_pre_data1", data1, 32'h1);
    stall = 1'b1;
    drive(1'b0, 5'd11, 32'hDEAD, 5'd12, 32'hBEEF, 32'h77, 5'd13, 3'b010, 1'b1, 1'b0);
    step();
    check("stl1_data1", data1, 32'h1);
    check("stl1_alu",   {29'b0, alu_ctrl_out}, 32'h5);
    check("stl1_rd",    {27'b0, rd_addr_out}, 32'h3);
    memwb_rd = 5'd7; memwb_we = 1'b1; memwb_data = 32'h99;
    #1 check("stl2_fwd", data1, 32'h99);
    step();
    no_fwd();
    #1 check("stl2_held_upd", data1, 32'h99);
    check("stl2_data2", data2, 32'h2);
    step();
    check("stl3_data1", data1, 32'h99);
    check("stl3_valid", {31'b0, valid_out}, 32'h1);
    check("stl3_rw",    {31'b0, reg_write_out}, 32'h1);
    check("stl3_alu",   {29'b0, alu_ctrl_out}, 32'h5);
    check("stl3_rd",    {27'b0, rd_addr_out}, 32'h3);

    // Flush together with stall gives a bubble
    flush = 1'b1;
    drive(1'b1, 5'd14, 32'h44, 5'd15, 32'h55, 32'h0, 5'd12, 3'b100, 1'b0, 1'b1);
    step();
    check("fl_valid", {31'b0, valid_out}, 32'h0);
    check("fl_rw",    {31'b0, reg_write_out}, 32'h0);
    check("fl_rd",    {27'b0, rd_addr_out}, 32'h0);
    check("fl_alu",   {29'b0, alu_ctrl_out}, 32'h0);
    check("fl_data1", data1, 32'h0);
    flush = 1'b0; stall = 1'b0;

    // Reset during a stall with a valid instruction held
    drive(1'b1, 5'd9, 32'h33, 5'd10, 32'h34, 32'h0, 5'd4, 3'b010, 1'b0, 1'b1);
    step();
    check("rs_pre_valid", {31'b0, valid_out}, 32'h1);
    stall = 1'b1; rst = 1'b1;
    step();
    check("rs_valid", {31'b0, valid_out}, 32'h0);
    check("rs_rw",    {31'b0, reg_write_out}, 32'h0);
    check("rs_alu",   {29'b0, alu_ctrl_out}, 32'h0);
    check("rs_rd",    {27'b0, rd_addr_out}, 32'h0);
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 5'd2, 32'h77, 5'd3, 32'h88, 32'h0, 5'd10, 3'b110, 1'b0, 1'b1);
    step();
    check("post_valid", {31'b0, valid_out}, 32'h1);
    check("post_rd",    {27'b0, rd_addr_out}, 32'hA);
    check("post_data1", data1, 32'h77);
    check("post_alu",   {29'b0, alu_ctrl_out}, 32'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
